// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter for a shared IO bus: IDLE -> ACCESS -> RESP.
// Optional access timeout with error response when IO_ARB_TIMEOUT_EN is defined.
module io_bus_arbiter #(
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic        m0_size,
  input  logic        m1_size,
  output logic        m0_done,
  output logic        m1_done,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m_err,
  output logic [31:0] io_addr,
  output logic [31:0] io_wr_val,
  output logic        io_write_en,
  output logic        io_read_en,
  output logic        io_data_size,
  input  logic [31:0] io_rd_val,
  input  logic        io_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [7:0] WS_LIM  = 8'(WAIT_STATES);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  // The counter only needs to reach the larger of the two thresholds before it stops.
  localparam logic [7:0] CNT_MAX = (WS_LIM > TO_LAST) ? WS_LIM : TO_LAST;

  state_t      state_q;
  logic        gnt_q;
  logic        last_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        size_q;
  logic [7:0]  cnt_q;
  logic        done0_q;
  logic        done1_q;
  logic        err_q;
  logic        busy_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic in_access_s;
  logic complete_s;
  logic timeout_s;
  logic grant_m1_s;

  assign in_access_s = (state_q == S_ACCESS);
  assign complete_s  = in_access_s && (cnt_q >= WS_LIM) && io_ready;
`ifdef IO_ARB_TIMEOUT_EN
  assign timeout_s   = in_access_s && !complete_s && (cnt_q >= TO_LAST);
`else
  assign timeout_s   = 1'b0;
`endif
  // On a tie the master not served most recently wins; last_q = 1 means m1 was last.
  assign grant_m1_s  = m1_req && (!m0_req || !last_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      size_q   <= 1'b0;
      cnt_q    <= 8'd0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            gnt_q   <= grant_m1_s;
            we_q    <= grant_m1_s ? m1_we    : m0_we;
            addr_q  <= grant_m1_s ? m1_addr  : m0_addr;
            wdata_q <= grant_m1_s ? m1_wdata : m0_wdata;
            size_q  <= grant_m1_s ? m1_size  : m0_size;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b1;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (complete_s || timeout_s) begin
            if (!we_q) begin
              if (gnt_q) rdata1_q <= complete_s ? io_rd_val : 32'hDEAD_BEEF;
              else       rdata0_q <= complete_s ? io_rd_val : 32'hDEAD_BEEF;
            end
            done0_q <= !gnt_q;
            done1_q <= gnt_q;
            err_q   <= timeout_s;
            state_q <= S_RESP;
          end else if (cnt_q < CNT_MAX) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_RESP: begin
          last_q  <= gnt_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign m0_done      = done0_q;
  assign m1_done      = done1_q;
  assign m0_rdata     = rdata0_q;
  assign m1_rdata     = rdata1_q;
  assign m_err        = err_q;
  assign busy         = busy_q;
  assign io_addr      = in_access_s ? addr_q  : 32'd0;
  assign io_wr_val    = in_access_s ? wdata_q : 32'd0;
  assign io_data_size = in_access_s ? size_q  : 1'b0;
  assign io_read_en   = in_access_s && !we_q;
  // A reset arriving in the completing cycle must not let the write strobe escape.
  assign io_write_en  = complete_s && we_q && !rst;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomised self-checking bench for io_bus_arbiter against a transaction-level model.
module tb_io_bus_arbiter;
  localparam int WS = 1;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = 32'd0, m1_addr = 32'd0, m0_wdata = 32'd0, m1_wdata = 32'd0;
  logic        m0_size = 1'b0, m1_size = 1'b0;
  logic        m0_done, m1_done, m_err, io_write_en, io_read_en, io_data_size, busy;
  logic [31:0] m0_rdata, m1_rdata, io_addr, io_wr_val;
  logic [31:0] io_rd_val = 32'd0;
  logic        io_ready = 1'b0;

  int          n_vec = 0;
  int          n_err = 0;
  bit          model_last;
  logic [31:0] model_rd0, model_rd1;

  always #5 clk = ~clk;

  io_bus_arbiter #(.WAIT_STATES(WS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_size(m0_size), .m1_size(m1_size),
    .m0_done(m0_done), .m1_done(m1_done), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m_err(m_err), .io_addr(io_addr), .io_wr_val(io_wr_val), .io_write_en(io_write_en),
    .io_read_en(io_read_en), .io_data_size(io_data_size), .io_rd_val(io_rd_val),
    .io_ready(io_ready), .busy(busy)
  );

  // One transaction from the IDLE cycle through RESP; d = ACCESS cycles with io_ready low.
  task automatic do_txn(input bit r0, input bit r1, input bit we0, input bit we1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input bit s0, input bit s1, input int d,
                        input bit fix_rdv, input logic [31:0] rdv, input bit drop,
                        output bit obs_m1);
    bit          w, we, sz;
    logic [31:0] a, wd, rv;
    int          len, wen_cnt, ren_cnt;
    logic [5:0]  flags, exp_flags;
    w   = (r0 && r1) ? !model_last : r1;
    we  = w ? we1 : we0;
    a   = w ? a1  : a0;
    wd  = w ? w1  : w0;
    sz  = w ? s1  : s0;
    len = ((d > WS) ? d : WS) + 1;
    wen_cnt = 0;
    ren_cnt = 0;
    rv  = 32'd0;
    @(posedge clk); #1;
    m0_req = r0; m1_req = r1; m0_we = we0; m1_we = we1;
    m0_addr = a0; m1_addr = a1; m0_wdata = w0; m1_wdata = w1;
    m0_size = s0; m1_size = s1; io_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, io_read_en, io_write_en, io_addr, io_wr_val, io_data_size} !== 68'd0) begin
      n_err++;
      $display("FAIL idle_bus: busy=%b ren=%b wen=%b addr=%h wval=%h sz=%b required all 0",
               busy, io_read_en, io_write_en, io_addr, io_wr_val, io_data_size);
    end
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      io_ready  = (k >= d);
      io_rd_val = fix_rdv ? rdv : $urandom;
      rv        = io_rd_val;
      m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
      m0_we = 1'($urandom); m1_we = 1'($urandom); m0_size = 1'($urandom); m1_size = 1'($urandom);
      if (drop) begin
        if (w) m1_req = 1'b0;
        else   m0_req = 1'b0;
      end
      @(negedge clk);
      if (io_write_en) wen_cnt++;
      if (io_read_en)  ren_cnt++;
      flags     = {busy, io_read_en, io_write_en, m0_done, m1_done, m_err};
      exp_flags = {1'b1, !we, (we && k == len - 1), 1'b0, 1'b0, 1'b0};
      n_vec++;
      if (flags !== exp_flags) begin
        n_err++;
        $display("FAIL access_ctl k=%0d: {busy,ren,wen,d0,d1,err}=%b required %b", k, flags, exp_flags);
      end
      n_vec++;
      if ({io_addr, io_wr_val, io_data_size} !== {a, wd, sz}) begin
        n_err++;
        $display("FAIL access_bus k=%0d: addr=%h wval=%h sz=%b required %h %h %b",
                 k, io_addr, io_wr_val, io_data_size, a, wd, sz);
      end
    end
    @(posedge clk); #1;
    io_ready = 1'b0;
    @(negedge clk);
    if (!we) begin
      if (w) model_rd1 = rv;
      else   model_rd0 = rv;
    end
    model_last = w;
    obs_m1 = m1_done;
    flags     = {busy, io_read_en, io_write_en, m0_done, m1_done, m_err};
    exp_flags = {1'b1, 1'b0, 1'b0, !w, w, 1'b0};
    n_vec++;
    if (flags !== exp_flags) begin
      n_err++;
      $display("FAIL resp_ctl: {busy,ren,wen,d0,d1,err}=%b required %b", flags, exp_flags);
    end
    n_vec++;
    if ({m0_rdata, m1_rdata} !== {model_rd0, model_rd1}) begin
      n_err++;
      $display("FAIL resp_rdata: m0=%h m1=%h required %h %h", m0_rdata, m1_rdata, model_rd0, model_rd1);
    end
    n_vec++;
    if (wen_cnt != (we ? 1 : 0) || ren_cnt != (we ? 0 : len)) begin
      n_err++;
      $display("FAIL strobe_count: wen=%0d ren=%0d required %0d %0d", wen_cnt, ren_cnt,
               (we ? 1 : 0), (we ? 0 : len));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({m0_done, m1_done, m_err, busy, io_write_en, io_read_en, io_data_size,
         io_addr, io_wr_val, m0_rdata, m1_rdata} !== 135'd0) begin
      n_err++;
      $display("FAIL reset_state: d0=%b d1=%b err=%b busy=%b wen=%b ren=%b rd0=%h rd1=%h required all 0",
               m0_done, m1_done, m_err, busy, io_write_en, io_read_en, m0_rdata, m1_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    model_last = 1'b1;
    model_rd0  = 32'd0;
    model_rd1  = 32'd0;
  endtask

  task automatic test_m0_write();
    bit o;
    do_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h0002_0008, 32'd0, 32'h0000_A5A5, 32'd0,
           1'b0, 1'b0, 0, 1'b0, 32'd0, 1'b0, o);
  endtask

  task automatic test_m1_read();
    bit o;
    do_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0002_0004, 32'd0, 32'd0,
           1'b0, 1'b1, 0, 1'b1, 32'h0000_1234, 1'b0, o);
  endtask

  task automatic test_round_robin();
    bit o;
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b1, 1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
             1'($urandom), 1'($urandom), 0, 1'b0, 32'd0, 1'b0, o);
      n_vec++;
      if (o !== 1'(i % 2)) begin
        n_err++;
        $display("FAIL round_robin i=%0d: m1 served=%b required %b", i, o, 1'(i % 2));
      end
    end
  endtask

  task automatic test_wait_ready();
    bit o;
    do_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'd0, 32'd0, 32'd0,
           1'b1, 1'b0, 5, 1'b0, 32'd0, 1'b0, o);
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0040; m0_wdata = 32'h1111_2222;
    io_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; io_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (io_write_en !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_wen: wen=%b required 0", io_write_en);
    end
    @(posedge clk); #1;
    rst = 1'b0; m0_req = 1'b0; io_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_vec++;
      if ({m0_done, m1_done, busy, io_write_en, io_read_en, io_addr} !== 37'd0) begin
        n_err++;
        $display("FAIL rst_mid_quiet k=%0d: d0=%b d1=%b busy=%b wen=%b ren=%b required all 0",
                 k, m0_done, m1_done, busy, io_write_en, io_read_en);
      end
      @(posedge clk); #1;
    end
    model_last = 1'b1;
    model_rd0  = 32'd0;
    model_rd1  = 32'd0;
    test_m0_write();
  endtask

  task automatic test_random();
    bit o, r0, r1;
    for (int i = 0; i < 40; i++) begin
      r0 = 1'($urandom);
      r1 = r0 ? 1'($urandom) : 1'b1;
      do_txn(r0, r1, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
             1'($urandom), 1'($urandom), int'($urandom_range(0, 6)), 1'b0, 32'd0,
             1'($urandom_range(0, 3) == 0), o);
    end
  endtask

`ifdef IO_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int ren_cnt;
    ren_cnt = 0;
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0FF0; io_ready = 1'b0;
    for (int k = 0; k < TO; k++) begin
      @(posedge clk); #1;
      m1_req = 1'b0;
      @(negedge clk);
      if (io_read_en) ren_cnt++;
      n_vec++;
      if ({m0_done, m1_done, io_write_en} !== 3'd0) begin
        n_err++;
        $display("FAIL timeout_wait k=%0d: d0=%b d1=%b wen=%b required 0", k, m0_done, m1_done, io_write_en);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if ({m1_done, m_err, m1_rdata, ren_cnt} !== {1'b1, 1'b1, 32'hDEAD_BEEF, TO}) begin
      n_err++;
      $display("FAIL timeout_resp: d1=%b err=%b rd1=%h ren=%0d required 1 1 deadbeef %0d",
               m1_done, m_err, m1_rdata, ren_cnt, TO);
    end
    model_rd1  = 32'hDEAD_BEEF;
    model_last = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_m0_write();
    test_m1_read();
    test_round_robin();
    test_wait_ready();
    test_reset_mid_access();
    test_random();
`ifdef IO_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
